// File: rtl/motoro3_pkg.sv
// Shared types and constants for the motoro3 gate-driver blocks.
package motoro3_pkg;

   typedef enum logic [1:0] {
      PH_OFF  = 2'd0,
      PH_DEAD = 2'd1,
      PH_HI   = 2'd2,
      PH_LO   = 2'd3
   } phase_state_e;

   // Dead-time loaded at reset: 2 us at a 10 MHz clock.
   localparam logic [7:0] DT_RST_DEFAULT = 8'd20;

endpackage

// File: rtl/motoro3_mos_deadtime_driver_if.sv
// Control/gate bundle between the commutation logic (master) and the gate driver (slave).
interface motoro3_mos_deadtime_driver_if #(
   parameter int NPH  = 3,
   parameter int DT_W = 8
);
   logic [NPH-1:0]  mosEnable;
   logic [NPH-1:0]  h1_L0;
   logic [DT_W-1:0] deadTime;
   logic            dtLoad;
   logic            faultIn;
   logic            faultClr;
   logic [NPH-1:0]  mosH;
   logic [NPH-1:0]  mosL;
   logic [NPH-1:0]  dtActive;
   logic            faultLatched;

   modport master (
      output mosEnable, h1_L0, deadTime, dtLoad, faultIn, faultClr,
      input  mosH, mosL, dtActive, faultLatched
   );

   modport slave (
      input  mosEnable, h1_L0, deadTime, dtLoad, faultIn, faultClr,
      output mosH, mosL, dtActive, faultLatched
   );
endinterface

// File: rtl/motoro3_mos_phase.sv
// One half-bridge leg: OFF/DEAD/HI/LO state machine with dead-time counter.
// State updates on the falling clock edge; gate outputs are flops.
module motoro3_mos_phase
   import motoro3_pkg::*;
#(
   parameter int DT_W = 8
) (
   input  logic            clk,
   input  logic            nRst,
   input  logic            en,
   input  logic            req,
   input  logic [DT_W-1:0] dt,
   output logic            mos_h,
   output logic            mos_l,
   output logic            dt_active
);

   localparam logic [DT_W-1:0] CNT_ZERO = {DT_W{1'b0}};
   localparam logic [DT_W-1:0] CNT_ONE  = {{(DT_W-1){1'b0}}, 1'b1};

   phase_state_e    state_d, state_q;
   logic [DT_W-1:0] cnt_d, cnt_q;
   logic            mos_h_d, mos_h_q;
   logic            mos_l_d, mos_l_q;
   logic            dt_active_d, dt_active_q;

   // Next state; the target side is the live request, so a reversal mid-DEAD just retargets.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!en) begin
         state_d = PH_OFF;
         cnt_d   = CNT_ZERO;
      end else begin
         case (state_q)
            PH_OFF: begin
               state_d = PH_DEAD;
               cnt_d   = dt;
            end
            PH_HI: begin
               if (!req) begin
                  state_d = PH_DEAD;
                  cnt_d   = dt;
               end else begin
                  state_d = PH_HI;
               end
            end
            PH_LO: begin
               if (req) begin
                  state_d = PH_DEAD;
                  cnt_d   = dt;
               end else begin
                  state_d = PH_LO;
               end
            end
            PH_DEAD: begin
               if (cnt_q != CNT_ZERO) begin
                  cnt_d = cnt_q - CNT_ONE;
               end else begin
                  state_d = req ? PH_HI : PH_LO;
               end
            end
            default: begin
               state_d = PH_OFF;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
      mos_h_d     = (state_d == PH_HI);
      mos_l_d     = (state_d == PH_LO);
      dt_active_d = (state_d == PH_DEAD);
   end

   // State, counter and gate flops; a single enum state makes H and L exclusive.
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q     <= PH_OFF;
         cnt_q       <= CNT_ZERO;
         mos_h_q     <= 1'b0;
         mos_l_q     <= 1'b0;
         dt_active_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mos_h_q     <= mos_h_d;
         mos_l_q     <= mos_l_d;
         dt_active_q <= dt_active_d;
      end
   end

   assign mos_h     = mos_h_q;
   assign mos_l     = mos_l_q;
   assign dt_active = dt_active_q;

endmodule

// File: rtl/motoro3_mos_deadtime_driver.sv
// Multi-phase half-bridge gate driver: dead-time register, fault latch, NPH phase legs.
// Fault latch present only when MOTORO3_MOS_FAULT_EN is defined.
module motoro3_mos_deadtime_driver
   import motoro3_pkg::*;
#(
   parameter int              NPH    = 3,
   parameter int              DT_W   = 8,
   parameter logic [DT_W-1:0] DT_RST = DT_W'(DT_RST_DEFAULT)
) (
   input logic                           clk,
   input logic                           nRst,
   motoro3_mos_deadtime_driver_if.slave  bus
);

   logic [DT_W-1:0] dt_d, dt_q;
   logic            fault_s;
   logic [NPH-1:0]  phase_en_s;
   logic [NPH-1:0]  mos_h_s;
   logic [NPH-1:0]  mos_l_s;
   logic [NPH-1:0]  dt_active_s;

   // Active dead-time capture; phases sample it only on DEAD entry.
   always_comb begin
      if (bus.dtLoad) begin
         dt_d = bus.deadTime;
      end else begin
         dt_d = dt_q;
      end
   end

   // Active dead-time register.
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         dt_q <= DT_RST;
      end else begin
         dt_q <= dt_d;
      end
   end

`ifdef MOTORO3_MOS_FAULT_EN
   logic fault_d, fault_q;

   // A live fault beats a clear in the same cycle.
   always_comb begin
      if (bus.faultIn) begin
         fault_d = 1'b1;
      end else if (bus.faultClr) begin
         fault_d = 1'b0;
      end else begin
         fault_d = fault_q;
      end
   end

   // Fault latch.
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end

   // Raw input is included so gates drop on the same edge the fault is seen.
   assign fault_s          = bus.faultIn | fault_q;
   assign bus.faultLatched = fault_q;
`else
   logic unused_fault_s;
   assign unused_fault_s   = bus.faultIn ^ bus.faultClr;
   assign fault_s          = 1'b0;
   assign bus.faultLatched = 1'b0;
`endif

   assign phase_en_s = bus.mosEnable & {NPH{~fault_s}};

   for (genvar gi = 0; gi < NPH; gi++) begin : g_phase
      motoro3_mos_phase #(
         .DT_W (DT_W)
      ) u_phase (
         .clk       (clk),
         .nRst      (nRst),
         .en        (phase_en_s[gi]),
         .req       (bus.h1_L0[gi]),
         .dt        (dt_q),
         .mos_h     (mos_h_s[gi]),
         .mos_l     (mos_l_s[gi]),
         .dt_active (dt_active_s[gi])
      );
   end

   assign bus.mosH     = mos_h_s;
   assign bus.mosL     = mos_l_s;
   assign bus.dtActive = dt_active_s;

endmodule
